ide_sector_engine: RTL and testbench
====================================

# ide_sector_engine

Parametrised ATA task-file register block with an internal sector buffer and a byte-wide backing-store port. It replaces the single-sector byte counter of the earlier IDE block with configurable sector size, multi-sector READ/WRITE SECTORS, LBA auto-increment, range checking and error reporting. It sits between the CPU bus (ce_n/oe_n/we_n strobes, 3-bit register address) and an on-board memory or flash controller.

## Interface
- SECTOR_BYTES, 512: bytes per sector; power of two, 4..4096.
- NUM_SECTORS, 65536: sectors in the backing store. LBA ≥ NUM_SECTORS is out of range.
- MEM_AW, $clog2(NUM_SECTORS*SECTOR_BYTES): backing-store byte-address width (derived).

- clk  in  1  single clock for the whole block.
- arst  in  1  reset; synchronous, active-high.
- ce_n, oe_n, we_n  in  1 each  bus chip enable, read strobe and write strobe; all active-low.
- address  in  3  register select: 0 data, 1 error (R), 2 sector count, 3/4/5 LBA[7:0]/[15:8]/[23:16], 7 command (W) / status (R).
- data_in  in  8  write data.
- data_out  out  8  read data.
- mem_req, mem_we  out  1 each  byte request; write (1) or read (0).
- mem_addr  out  MEM_AW  LBA*SECTOR_BYTES + byte index.
- mem_wdata  out  8 ; mem_rdata  in  8 ; mem_ack  in  1  one byte completes per cycle with mem_req&mem_ack.

## Operation
- Write event: first cycle with ce_n=0 and we_n=0 after we_n was sampled 1. Read-pop event: first cycle with oe_n=1 after a cycle with ce_n=0, oe_n=0, address=0.
- data_out: combinational mux on address; 0x00 when ce_n=1 or oe_n=1. Status = {BSY,DRDY,2'b0,DRQ,2'b0,ERR}. Error = {3'b0,IDNF,1'b0,ABRT,2'b0}.
- Sector count 0 means 256. LBA and count registers are readable and show live progress.
- FSM states: IDLE, FILL, HOST_RD, HOST_WR, FLUSH.
  - IDLE (DRDY=1): command write 0x20 goes to FILL; 0x30 goes to HOST_WR. On either, ERR and the error register clear first. Any other opcode sets ERR=1, ABRT=1 and stays in IDLE.
  - Range check: a 0x20/0x30 with LBA ≥ NUM_SECTORS sets ERR=1, IDNF=1 and stays in IDLE. The check repeats before each subsequent sector; on failure the FSM goes to IDLE with ERR/IDNF set and count left at the remaining value.
  - FILL (BSY=1): reads SECTOR_BYTES bytes from the backing store into the buffer, then goes to HOST_RD.
  - HOST_RD (DRQ=1): each read-pop advances the byte pointer. After the last byte, count decrements. If count is then 0, go to IDLE. Otherwise LBA increments and the FSM returns to FILL.
  - HOST_WR (DRQ=1): each data write stores one byte. After the last byte, go to FLUSH.
  - FLUSH (BSY=1): writes the buffer to the backing store. Then count decrements; LBA increments if count ≠ 0; next state is HOST_WR or IDLE.
- Register writes while BSY=1 are ignored.
- A command write while DRQ=1 aborts the transfer and is decoded as if in IDLE.
- Reads of the data register outside HOST_RD return 0x00 and are not popped. Writes to it outside HOST_WR are dropped.
- LBA wraps 0xFFFFFF→0 (the range check catches it).

## Timing
- Reset values:
  - data_out 0x00; status 0x40; error 0x00; count 0x01; LBA 0.
  - mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0.
  - Buffer contents undefined. FSM in IDLE.
- Reset mid-transfer returns to IDLE on the next edge and drops mem_req without waiting for mem_ack.
- Command write at edge N: BSY (or DRQ for 0x30) is visible from cycle N+1. mem_req asserts at N+1.
- mem_req stays high back-to-back until SECTOR_BYTES acks have occurred. mem_addr and mem_wdata hold stable while not acked.
- With mem_ack tied high, FILL/FLUSH takes exactly SECTOR_BYTES cycles. DRQ (or DRDY) is set one cycle after the last ack.
- Read-pop: the next byte appears on data_out the cycle after oe_n rises.

## Configuration
- IDE_IRQ_EN defined: adds output irq (1 bit, reset 0).
  - irq sets on entry to HOST_RD, HOST_WR, and to IDLE from FLUSH or from any error.
  - irq clears on a status read (ce_n=0, oe_n=0, address=7).
- IDE_IRQ_EN undefined: no irq port or logic. Hosts poll status.

## Test plan
- Reset, then read address 7 → 0x40; address 2 → 0x01; addresses 3/4/5 → 0x00.
- SECTOR_BYTES=4, mem_ack=1, memory preloaded bytes 0xA0..0xA7 at LBA 0–1. Write count=2, LBA=0, cmd 0x20 → BSY for 4 cycles, then DRQ. Eight pops → 0xA0..0xA7. Final status 0x40; LBA reads 1; count reads 0.
- Write cmd 0x30, count=1, LBA=5. Write 0x11,0x22,0x33,0x44 → FLUSH shows mem_we=1, mem_addr 20..23 with those bytes in order. Status returns 0x40.
- NUM_SECTORS=8, LBA=8, cmd 0x20 → no mem_req; status 0x41; error 0x10.
- Cmd 0x99 → status 0x41, error 0x04. Next cmd 0x20 with valid LBA clears ERR.
- mem_ack toggling 1-of-3 cycles during FILL → mem_addr is held while not acked. With IDE_IRQ_EN, irq rises at DRQ and clears after a status read. Asserting arst mid-FILL → mem_req=0 and status 0x40 the next cycle.

Source files
------------

// File: rtl/ide_sector_engine_if.sv
// Bus bundle for ide_sector_engine: CPU task-file strobes plus the byte-wide backing-store port.
// The slave modport is the engine's view; master is the host/memory side.
interface ide_sector_engine_if #(
  parameter int MEM_AW = 25
);
  logic              ce_n;
  logic              oe_n;
  logic              we_n;
  logic [2:0]        address;
  logic [7:0]        data_in;
  logic [7:0]        data_out;
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport slave (
    input  ce_n, oe_n, we_n, address, data_in, mem_rdata, mem_ack,
    output data_out, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ce_n, oe_n, we_n, address, data_in, mem_rdata, mem_ack,
    input  data_out, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ide_sector_engine.sv
// ATA task-file register block with a one-sector buffer and multi-sector READ/WRITE SECTORS.
// Define IDE_IRQ_EN to add the irq output; otherwise hosts poll status.
module ide_sector_engine #(
  parameter int SECTOR_BYTES = 512,
  parameter int NUM_SECTORS  = 65536,
  parameter int MEM_AW       = $clog2(NUM_SECTORS * SECTOR_BYTES)
) (
  input logic clk,
  input logic arst,
  ide_sector_engine_if.slave bus
`ifdef IDE_IRQ_EN
  ,
  output logic irq
`endif
);

  localparam int              PW        = $clog2(SECTOR_BYTES);
  localparam logic [PW-1:0]   LP_LAST   = PW'(SECTOR_BYTES - 1);
  localparam logic [24:0]     LP_NSEC   = 25'(NUM_SECTORS);
  localparam logic [7:0]      CMD_READ  = 8'h20;
  localparam logic [7:0]      CMD_WRITE = 8'h30;
  localparam logic [2:0]      A_DATA = 3'd0, A_ERR = 3'd1, A_COUNT = 3'd2;
  localparam logic [2:0]      A_LBA0 = 3'd3, A_LBA1 = 3'd4, A_LBA2 = 3'd5, A_CMD = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_HOST_RD, S_HOST_WR, S_FLUSH} state_t;

  state_t        r_state, w_next_state;
  logic [7:0]    r_count;
  logic [23:0]   r_lba;
  logic [PW-1:0] r_ptr;
  logic          r_err, r_idnf, r_abrt;
  logic          r_we_q, r_rd_q;
  logic [7:0]    r_buf [SECTOR_BYTES];

  logic          w_bsy, w_drq, w_drdy;
  logic [7:0]    w_status;
  logic          w_reg_wr, w_cmd_wr, w_cmd_ok, w_cmd_go, w_dat_wr, w_pop, w_ack;
  logic          w_last, w_more, w_sec_done, w_lba_bad, w_next_bad;
  logic [23:0]   w_lba_inc;

  // Strobe edges: a write lands on the first low we_n cycle, a pop when oe_n rises after a data read.
  assign w_reg_wr   = !bus.ce_n && !bus.we_n && r_we_q && !w_bsy;
  assign w_cmd_wr   = w_reg_wr && (bus.address == A_CMD);
  assign w_cmd_ok   = (bus.data_in == CMD_READ) || (bus.data_in == CMD_WRITE);
  assign w_lba_bad  = {1'b0, r_lba} >= LP_NSEC;
  assign w_cmd_go   = w_cmd_ok && !w_lba_bad;
  assign w_dat_wr   = w_reg_wr && (bus.address == A_DATA) && (r_state == S_HOST_WR);
  assign w_pop      = r_rd_q && bus.oe_n && (r_state == S_HOST_RD);
  assign w_ack      = bus.mem_req && bus.mem_ack;
  assign w_last     = (r_ptr == LP_LAST);
  assign w_more     = (r_count != 8'd1);
  assign w_lba_inc  = r_lba + 24'd1;
  assign w_next_bad = {1'b0, w_lba_inc} >= LP_NSEC;
  assign w_sec_done = w_last && (w_pop || ((r_state == S_FLUSH) && w_ack));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (arst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default first so no path through this block leaves a variable unassigned (no latch).
    w_next_state = r_state;
    if (w_cmd_wr) begin
      if (w_cmd_go) w_next_state = (bus.data_in == CMD_READ) ? S_FILL : S_HOST_WR;
      else          w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_FILL:    if (w_ack && w_last) w_next_state = S_HOST_RD;
        S_HOST_RD: if (w_sec_done) w_next_state = (w_more && !w_next_bad) ? S_FILL : S_IDLE;
        S_HOST_WR: if (w_dat_wr && w_last) w_next_state = S_FLUSH;
        S_FLUSH:   if (w_sec_done) w_next_state = (w_more && !w_next_bad) ? S_HOST_WR : S_IDLE;
        default:   ;
      endcase
    end
  end

  always_comb begin
    w_bsy          = 1'b0;
    w_drq          = 1'b0;
    w_drdy         = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = 8'h00;
    case (r_state)
      S_IDLE:    w_drdy = 1'b1;
      S_FILL: begin
        w_bsy        = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = MEM_AW'({r_lba, r_ptr});
      end
      S_HOST_RD, S_HOST_WR: w_drq = 1'b1;
      S_FLUSH: begin
        w_bsy         = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = MEM_AW'({r_lba, r_ptr});
        bus.mem_wdata = r_buf[r_ptr];
      end
      default: ;
    endcase
    w_status     = {w_bsy, w_drdy, 2'b00, w_drq, 2'b00, r_err};
    bus.data_out = 8'h00;
    if (!bus.ce_n && !bus.oe_n) begin
      case (bus.address)
        A_DATA:  bus.data_out = (r_state == S_HOST_RD) ? r_buf[r_ptr] : 8'h00;
        A_ERR:   bus.data_out = {3'b000, r_idnf, 1'b0, r_abrt, 2'b00};
        A_COUNT: bus.data_out = r_count;
        A_LBA0:  bus.data_out = r_lba[7:0];
        A_LBA1:  bus.data_out = r_lba[15:8];
        A_LBA2:  bus.data_out = r_lba[23:16];
        A_CMD:   bus.data_out = w_status;
        default: bus.data_out = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_count <= 8'd1;
      r_lba   <= 24'd0;
      r_ptr   <= '0;
      r_err   <= 1'b0;
      r_idnf  <= 1'b0;
      r_abrt  <= 1'b0;
      r_we_q  <= 1'b0;
      r_rd_q  <= 1'b0;
    end else begin
      r_we_q <= bus.we_n;
      r_rd_q <= !bus.ce_n && !bus.oe_n && (bus.address == A_DATA);
      if (w_pop || w_dat_wr || w_ack) r_ptr <= r_ptr + PW'(1);
      if (w_sec_done) begin
        r_count <= r_count - 8'd1;
        if (w_more) begin
          r_lba <= w_lba_inc;
          if (w_next_bad) begin
            r_err  <= 1'b1;
            r_idnf <= 1'b1;
          end
        end
      end
      // Register writes come last so a command or count/LBA load wins over transfer progress.
      if (w_reg_wr) begin
        case (bus.address)
          A_COUNT: r_count        <= bus.data_in;
          A_LBA0:  r_lba[7:0]     <= bus.data_in;
          A_LBA1:  r_lba[15:8]    <= bus.data_in;
          A_LBA2:  r_lba[23:16]   <= bus.data_in;
          A_CMD: begin
            r_ptr <= '0;
            if (w_cmd_ok) begin
              r_err  <= w_lba_bad;
              r_idnf <= w_lba_bad;
              r_abrt <= 1'b0;
            end else begin
              r_err  <= 1'b1;
              r_idnf <= 1'b0;
              r_abrt <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the sector buffer carries no reset; its contents are don't-care until filled.
  always_ff @(posedge clk) begin
    if ((r_state == S_FILL) && w_ack) r_buf[r_ptr] <= bus.mem_rdata;
    else if (w_dat_wr)                r_buf[r_ptr] <= bus.data_in;
  end

`ifdef IDE_IRQ_EN
  logic r_irq;
  logic w_irq_set, w_status_rd;

  assign w_status_rd = !bus.ce_n && !bus.oe_n && (bus.address == A_CMD);
  assign w_irq_set   = ((w_next_state != r_state) &&
                        ((w_next_state == S_HOST_RD) || (w_next_state == S_HOST_WR))) ||
                       ((r_state == S_FLUSH) && (w_next_state == S_IDLE)) ||
                       (w_cmd_wr && !w_cmd_go) ||
                       (w_sec_done && w_more && w_next_bad);

  always_ff @(posedge clk) begin
    if (arst)             r_irq <= 1'b0;
    else if (w_irq_set)   r_irq <= 1'b1;
    else if (w_status_rd) r_irq <= 1'b0;
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_ide_sector_engine.sv
// Directed bench for ide_sector_engine with 4-byte sectors and 8 sectors of backing store.
// Covers reset values, multi-sector read, write/flush, range and opcode errors, slow acks, reset mid-fill.
module tb_ide_sector_engine;

  localparam int SB = 4;
  localparam int NS = 8;
  localparam int AW = 5;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0]    mem [32];
  logic [AW-1:0] wr_addr_q [$];
  logic [7:0]    wr_data_q [$];
  logic [7:0]    exp_wr [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

`ifdef IDE_IRQ_EN
  logic irq;
`endif

  ide_sector_engine_if #(.MEM_AW(AW)) bus ();

  ide_sector_engine #(
    .SECTOR_BYTES(SB),
    .NUM_SECTORS (NS),
    .MEM_AW      (AW)
  ) dut (
    .clk (clk),
    .arst(arst),
    .bus (bus)
`ifdef IDE_IRQ_EN
    ,
    .irq (irq)
`endif
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];

  // Backing-store write log, sampled mid-cycle while the request is stable.
  always @(negedge clk) begin
    if (!arst && bus.mem_req && bus.mem_ack && bus.mem_we) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.ce_n    = 1'b1;
    bus.oe_n    = 1'b1;
    bus.we_n    = 1'b1;
    bus.address = 3'd0;
    bus.data_in = 8'h00;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.ce_n    = 1'b0;
    bus.we_n    = 1'b0;
    bus.address = a;
    bus.data_in = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.ce_n    = 1'b0;
    bus.oe_n    = 1'b0;
    bus.address = a;
    #1 d = bus.data_out;
    @(negedge clk);
    bus.ce_n = 1'b1;
    bus.oe_n = 1'b1;
  endtask

  task automatic read_check(input logic [2:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] v;
    bus_read(a, v);
    check(tag, 32'(v), 32'(exp));
  endtask

  task automatic wait_status(input logic [7:0] exp, input string tag);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 20; i++) begin
      bus_read(3'd7, s);
      if (s == exp) break;
    end
    check(tag, 32'(s), 32'(exp));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = (i < 8) ? (8'hA0 + 8'(i)) : 8'h00;
    bus_idle();
    bus.mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    arst = 1'b0;

    // Reset state
    #1;
    check("rst_data_out", 32'(bus.data_out), 32'h00);
    check("rst_mem_req", 32'(bus.mem_req), 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'h00);
`ifdef IDE_IRQ_EN
    check("rst_irq", 32'(irq), 32'h0);
`endif
    read_check(3'd7, 8'h40, "rst_status");
    read_check(3'd1, 8'h00, "rst_error");
    read_check(3'd2, 8'h01, "rst_count");
    read_check(3'd3, 8'h00, "rst_lba0");
    read_check(3'd4, 8'h00, "rst_lba1");
    read_check(3'd5, 8'h00, "rst_lba2");

    // Two-sector READ SECTORS from LBA 0
    bus_write(3'd2, 8'd2);
    bus_write(3'd3, 8'd0);
    bus_write(3'd4, 8'd0);
    bus_write(3'd5, 8'd0);
    bus_write(3'd7, 8'h20);
    bus.ce_n    = 1'b0;
    bus.oe_n    = 1'b0;
    bus.address = 3'd7;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("fill_bsy_%0d", i), 32'(bus.data_out), 32'h80);
      check($sformatf("fill_addr_%0d", i), 32'(bus.mem_addr), 32'(i));
      @(negedge clk);
    end
    #1 check("fill_drq", 32'(bus.data_out), 32'h08);
`ifdef IDE_IRQ_EN
    check("irq_at_drq", 32'(irq), 32'h1);
`endif
    @(negedge clk);
    bus_idle();
`ifdef IDE_IRQ_EN
    #1 check("irq_cleared", 32'(irq), 32'h0);
`endif
    for (int i = 0; i < 4; i++) read_check(3'd0, 8'hA0 + 8'(i), $sformatf("pop_s0_%0d", i));
    read_check(3'd7, 8'h80, "bsy_between_sectors");
    wait_status(8'h08, "drq_sector1");
    for (int i = 4; i < 8; i++) read_check(3'd0, 8'hA0 + 8'(i), $sformatf("pop_s1_%0d", i));
    read_check(3'd7, 8'h40, "rd_done_status");
    read_check(3'd3, 8'h01, "rd_done_lba");
    read_check(3'd2, 8'h00, "rd_done_count");
    read_check(3'd0, 8'h00, "data_outside_rd");

    // One-sector WRITE SECTORS to LBA 5
    bus_write(3'd2, 8'd1);
    bus_write(3'd3, 8'd5);
    bus_write(3'd7, 8'h30);
    read_check(3'd7, 8'h08, "wr_drq");
    for (int i = 0; i < 4; i++) bus_write(3'd0, exp_wr[i]);
    wait_status(8'h40, "wr_done_status");
    check("flush_count", 32'(wr_addr_q.size()), 32'd4);
    if (wr_addr_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("flush_addr_%0d", i), 32'(wr_addr_q[i]), 32'(20 + i));
        check($sformatf("flush_data_%0d", i), 32'(wr_data_q[i]), 32'(exp_wr[i]));
      end
    end
    read_check(3'd2, 8'h00, "wr_done_count");
    read_check(3'd3, 8'h05, "wr_done_lba");

    // Out-of-range LBA
    bus_write(3'd3, 8'd8);
    bus_write(3'd7, 8'h20);
    #1 check("range_no_req", 32'(bus.mem_req), 32'h0);
`ifdef IDE_IRQ_EN
    check("irq_on_error", 32'(irq), 32'h1);
`endif
    read_check(3'd7, 8'h41, "range_status");
    read_check(3'd1, 8'h10, "range_error");

    // Unknown opcode
    bus_write(3'd7, 8'h99);
    read_check(3'd7, 8'h41, "abrt_status");
    read_check(3'd1, 8'h04, "abrt_error");

    // Slow backing store: one ack in three cycles, address must hold between acks
    bus_write(3'd2, 8'd1);
    bus_write(3'd3, 8'd1);
    bus.mem_ack = 1'b0;
    bus_write(3'd7, 8'h20);
    for (int k = 0; k < 12; k++) begin
      bus.mem_ack = ((k % 3) == 2);
      #1;
      check($sformatf("slow_req_%0d", k), 32'(bus.mem_req), 32'h1);
      check($sformatf("slow_addr_%0d", k), 32'(bus.mem_addr), 32'(4 + k / 3));
      @(negedge clk);
    end
    bus.mem_ack = 1'b1;
    read_check(3'd7, 8'h08, "slow_drq_err_clear");
    read_check(3'd1, 8'h00, "slow_error_clear");
    read_check(3'd0, 8'hA4, "slow_byte0");

    // Command during DRQ restarts a fill; reset mid-fill drops the request
    bus_write(3'd7, 8'h20);
    #1 check("abort_refill_req", 32'(bus.mem_req), 32'h1);
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    #1 check("rst_mid_fill_req", 32'(bus.mem_req), 32'h0);
    bus.ce_n    = 1'b0;
    bus.oe_n    = 1'b0;
    bus.address = 3'd7;
    #1 check("rst_mid_fill_status", 32'(bus.data_out), 32'h40);
`ifdef IDE_IRQ_EN
    check("rst_mid_fill_irq", 32'(irq), 32'h0);
`endif
    bus_idle();
    read_check(3'd2, 8'h01, "rst_mid_fill_count");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
